// File: rtl/car_emitter_pkg.sv
// rtl/car_emitter_pkg.sv - shared types and constants for the car sensor emitter
package car_emitter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEAD    = 3'd1,
    OVERLAP = 3'd2,
    TRAIL   = 3'd3,
    GAP     = 3'd4
  } state_t;

  localparam logic DIR_ENTER = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bcd_updown_99.sv
// rtl/bcd_updown_99.sv - two-digit BCD up/down counter saturating at 00 and 99
module bcd_updown_99 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [3:0] o_hi,
  output logic [3:0] o_lo
);

  logic [3:0] r_hi;
  logic [3:0] r_lo;
  logic       w_at_max;
  logic       w_at_min;

  assign w_at_max = (r_hi == 4'd9) && (r_lo == 4'd9);
  assign w_at_min = (r_hi == 4'd0) && (r_lo == 4'd0);

  // Simultaneous inc and dec cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= 4'd0;
      r_lo <= 4'd0;
    end else if (i_inc && !i_dec && !w_at_max) begin
      if (r_lo == 4'd9) begin
        r_lo <= 4'd0;
        r_hi <= r_hi + 4'd1;
      end else begin
        r_lo <= r_lo + 4'd1;
      end
    end else if (i_dec && !i_inc && !w_at_min) begin
      if (r_lo == 4'd0) begin
        r_lo <= 4'd9;
        r_hi <= r_hi - 4'd1;
      end else begin
        r_lo <= r_lo - 4'd1;
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/car_sensor_emitter.sv
// rtl/car_sensor_emitter.sv - plays one two-sensor vehicle passage per request; CAR_EMITTER_AUTO_EN adds LFSR auto mode
module car_sensor_emitter
  import car_emitter_pkg::*;
#(
  parameter int HOLD_CYC = 3,
  parameter int OVL_CYC  = 2,
  parameter int GAP_CYC  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef CAR_EMITTER_AUTO_EN
  input  logic       auto_en,
`endif
  input  logic       req_valid,
  input  logic       req_dir,
  output logic       req_ready,
  output logic       s1,
  output logic       s2,
  output logic       busy,
  output logic       done,
  output logic [3:0] tally_hi,
  output logic [3:0] tally_lo
);

  localparam int CW = $clog2(max3(HOLD_CYC, OVL_CYC, GAP_CYC) + 1);
  localparam logic [CW-1:0] C_HOLD = CW'(HOLD_CYC);
  localparam logic [CW-1:0] C_OVL  = CW'(OVL_CYC);
  localparam logic [CW-1:0] C_GAP  = CW'(GAP_CYC);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_TWO  = CW'(2);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_dir;
  logic          r_s1;
  logic          r_s2;
  logic          r_done;
  logic          w_start;
  logic          w_dir;
  logic          w_inc;
  logic          w_dec;

`ifdef CAR_EMITTER_AUTO_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  // An external request wins over the self-timed launch in the same cycle
  assign w_start = req_valid || (auto_en && (r_lfsr[3:0] == 4'd0));
  assign w_dir   = req_valid ? req_dir : r_lfsr[4];
`else
  assign w_start = req_valid;
  assign w_dir   = req_dir;
`endif

  // Sensor levels are registered alongside each state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dir   <= DIR_ENTER;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_start) begin
            r_state <= LEAD;
            r_cnt   <= C_HOLD;
            r_dir   <= w_dir;
            r_s1    <= (w_dir == DIR_ENTER);
            r_s2    <= (w_dir == DIR_EXIT);
          end
        end
        LEAD: begin
          if (r_cnt == C_ONE) begin
            r_state <= OVERLAP;
            r_cnt   <= C_OVL;
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        OVERLAP: begin
          if (r_cnt == C_ONE) begin
            r_state <= TRAIL;
            r_cnt   <= C_HOLD;
            r_s1    <= (r_dir == DIR_EXIT);
            r_s2    <= (r_dir == DIR_ENTER);
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        TRAIL: begin
          if (r_cnt == C_ONE) begin
            r_state <= GAP;
            r_cnt   <= C_GAP;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_done  <= (C_GAP == C_ONE);
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        GAP: begin
          if (r_cnt == C_ONE) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end else begin
            r_cnt  <= r_cnt - C_ONE;
            r_done <= (r_cnt == C_TWO);
          end
        end
        default: begin
          r_state <= IDLE;
          r_s1    <= 1'b0;
          r_s2    <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign w_inc = r_done && (r_dir == DIR_ENTER);
  assign w_dec = r_done && (r_dir == DIR_EXIT);

  bcd_updown_99 u_tally (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_inc),
    .i_dec (w_dec),
    .o_hi  (tally_hi),
    .o_lo  (tally_lo)
  );

  assign s1        = r_s1;
  assign s2        = r_s2;
  assign done      = r_done;
  assign busy      = (r_state != IDLE);
  assign req_ready = (r_state == IDLE);

endmodule

// File: doc/car_sensor_emitter.md
# car_sensor_emitter

Drives the paired lane-sensor lines that the car counters consume: for each accepted request it plays out one complete vehicle passage as an ordered two-sensor pulse sequence (entering: s1 leads, exiting: s2 leads). It is the transmit side of the sensor interface, used for board bring-up and as a bench stimulus source for the lane counters and traffic timer. It also keeps a BCD net-occupancy tally, the golden value the downstream counter digits must match.

## Interface
- HOLD_CYC, 3, cycles each sensor is asserted alone (lead and trail phases), ≥1
- OVL_CYC, 2, cycles both sensors are asserted together, ≥1
- GAP_CYC, 4, cycles both sensors are low after a passage, ≥1
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request to emit one vehicle passage
- req_dir  in  1  0 = enter (s1 leads), 1 = exit (s2 leads); sampled on acceptance
- req_ready  out  1  high only in IDLE
- s1  out  1  first lane sensor line, registered
- s2  out  1  second lane sensor line, registered
- busy  out  1  passage in progress (not IDLE)
- done  out  1  one-cycle pulse, last GAP cycle
- tally_hi  out  4  BCD tens of net occupancy
- tally_lo  out  4  BCD units of net occupancy

## Operation
- States: IDLE → LEAD → OVERLAP → TRAIL → GAP → IDLE.
- IDLE: s1=s2=0, req_ready=1. Accept on req_valid&req_ready; latch req_dir; go to LEAD.
- LEAD (HOLD_CYC cycles): leading sensor=1 only (s1 if enter, s2 if exit).
- OVERLAP (OVL_CYC cycles): s1=s2=1.
- TRAIL (HOLD_CYC cycles): trailing sensor=1 only.
- GAP (GAP_CYC cycles): s1=s2=0; done=1 in final GAP cycle.
- Phase counter: width $clog2(max(HOLD_CYC,OVL_CYC,GAP_CYC)+1), loaded per phase, counts down; phase exits when it reaches 1.
- Tally: on done, enter → +1, exit → −1, BCD (lo wraps 9→0 with carry into hi, 0→9 with borrow). Saturates: enter at 99 stays 99, exit at 00 stays 00.
- req_valid while busy is ignored (not queued); req_dir changes during a passage have no effect.
- s1 and s2 never both fall or both rise in the same cycle.

## Timing
- Reset (async, immediate): state IDLE, s1=s2=0, req_ready=1, busy=0, done=0, tally 00. Reset mid-passage aborts it; no tally update.
- Acceptance at edge N → leading sensor high from cycle N+1; busy high from N+1, req_ready low from N+1.
- Passage length L = 2·HOLD_CYC + OVL_CYC + GAP_CYC cycles (N+1 … N+L); done in cycle N+L; tally updated and req_ready=1 in cycle N+L+1.
- Back-to-back: request held high is accepted at edge ending cycle N+L+1 → next passage starts N+L+2. Minimum car spacing L+1 cycles.

## Configuration
- CAR_EMITTER_AUTO_EN defined: adds input auto_en (1 bit) and a 16-bit Galois LFSR (taps 16,14,13,11; reset seed 16'hACE1) stepping every cycle. In IDLE with auto_en=1 and req_valid=0, a passage starts when lfsr[3:0]==0, direction lfsr[4]; external req_valid has priority in the same cycle.
- Not defined: no auto_en port, no LFSR; passages only from req_valid.

## Structure
- Package car_emitter_pkg: state enum (IDLE, LEAD, OVERLAP, TRAIL, GAP), DIR_ENTER=1'b0, DIR_EXIT=1'b1, LFSR seed and tap constants.
- One sub-module: bcd_updown_99 (inc/dec strobes, saturating 00..99, async active-low reset, outputs hi/lo BCD).

## Test plan
- Reset asserted then released, no request → s1=s2=0, req_ready=1, busy=0, tally 00.
- Defaults, enter accepted at edge 0 → s1 cycles 1–5, s2 cycles 4–8, both low 9–12, done in cycle 12, tally 01 and req_ready=1 in cycle 13.
- Exit request with tally 00 → s2 cycles 1–5, s1 cycles 4–8, done cycle 12, tally stays 00.
- 101 consecutive enters, req_valid held high → starts every 13 cycles, tally 99 after the 99th and stays 99; one exit → 98.
- rst_n low in cycle 5 (OVERLAP) of an enter → s1=s2=0 same cycle, tally 00, req_ready=1 after release; new enter completes normally.
- req_dir toggled and req_valid pulsed during busy → ignored; sequence and tally match original direction only.
